// File: rtl/fcs_tx_ctrl.sv
// Transmit FCS sequencer: forwards frame bytes, zero-pads short frames, feeds every
// forwarded byte to an external byte-wide CRC-32 engine and appends the 4-byte FCS.
module fcs_tx_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int CRC_WIDTH   = 32,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  crc_init,
    output logic                  crc_enable,
    output logic [DATA_WIDTH-1:0] crc_data,
    input  logic [CRC_WIDTH-1:0]  crc_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAD,
        S_CRC_WAIT,
        S_FCS
    } state_t;

    localparam logic [16:0] MIN_CNT = 17'(MIN_PAYLOAD);

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   out_data_reg;
    logic                    out_valid_reg;
    logic                    out_last_reg;
    logic [15:0]             byte_cnt_reg, byte_cnt_next;
    logic [CRC_WIDTH-1:0]    fcs_reg;
    logic [1:0]              fcs_idx_reg, fcs_idx_next;
    logic                    run_reg;

    logic                    free;
    logic                    in_ready_c;
    logic                    in_xfer;
    logic                    load;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    load_last;
    logic                    crc_en_c;
    logic                    capture_fcs;
    logic [16:0]             cnt_inc;
    logic [15:0]             cnt_sat;
    logic [CRC_WIDTH-1:0]    fcs_shifted;
    logic [DATA_WIDTH-1:0]   fcs_byte;
    logic [DATA_WIDTH-1:0]   fcs_byte_rev;

    assign free    = !out_valid_reg || out_ready;
    assign in_xfer = in_valid && in_ready_c;
    assign cnt_inc = {1'b0, byte_cnt_reg} + 17'd1;
    // Saturate so that jumbo frames never wrap back below the pad threshold.
    assign cnt_sat = (cnt_inc > MIN_CNT) ? byte_cnt_reg : cnt_inc[15:0];

    // FCS byte k is the top byte of fcs shifted left by 8k, sent bit-reversed.
    assign fcs_shifted = fcs_reg << (5'd8 * {3'd0, fcs_idx_reg});
    assign fcs_byte    = fcs_shifted[CRC_WIDTH-1 -: DATA_WIDTH];

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
            assign fcs_byte_rev[gi] = fcs_byte[DATA_WIDTH-1-gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        fcs_idx_next  = fcs_idx_reg;
        in_ready_c    = 1'b0;
        load          = 1'b0;
        load_data     = '0;
        load_last     = 1'b0;
        crc_en_c      = 1'b0;
        capture_fcs   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // run_reg keeps in_ready low while reset is (or was just) asserted.
                in_ready_c = free && run_reg;
                if (in_xfer) begin
                    load          = 1'b1;
                    load_data     = in_data;
                    crc_en_c      = 1'b1;
                    byte_cnt_next = 16'd1;
                    if (in_last)
                        state_next = (MIN_PAYLOAD > 1) ? S_PAD : S_CRC_WAIT;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready_c = free;
                if (in_xfer) begin
                    load          = 1'b1;
                    load_data     = in_data;
                    crc_en_c      = 1'b1;
                    byte_cnt_next = cnt_sat;
                    if (in_last)
                        state_next = (cnt_inc < MIN_CNT) ? S_PAD : S_CRC_WAIT;
                end
            end
            S_PAD: begin
                if (free) begin
                    load          = 1'b1;
                    load_data     = '0;
                    crc_en_c      = 1'b1;
                    byte_cnt_next = cnt_sat;
                    if (cnt_inc >= MIN_CNT)
                        state_next = S_CRC_WAIT;
                end
            end
            S_CRC_WAIT: begin
                // Engine result of the final byte is visible this cycle.
                capture_fcs  = 1'b1;
                fcs_idx_next = 2'd0;
                state_next   = S_FCS;
            end
            S_FCS: begin
                if (free) begin
                    load         = 1'b1;
                    load_data    = fcs_byte_rev;
                    load_last    = (fcs_idx_reg == 2'd3);
                    fcs_idx_next = fcs_idx_reg + 2'd1;
                    if (fcs_idx_reg == 2'd3) begin
                        state_next    = S_IDLE;
                        byte_cnt_next = 16'd0;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            byte_cnt_reg  <= '0;
            fcs_reg       <= '0;
            fcs_idx_reg   <= '0;
            run_reg       <= 1'b0;
        end else begin
            run_reg      <= 1'b1;
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            fcs_idx_reg  <= fcs_idx_next;
            if (capture_fcs)
                fcs_reg <= ~crc_value;
            if (load) begin
                out_data_reg  <= load_data;
                out_valid_reg <= 1'b1;
                out_last_reg  <= load_last;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign in_ready   = in_ready_c;
    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign out_last   = out_last_reg;
    assign crc_init   = (state_reg == S_IDLE);
    assign crc_enable = crc_en_c;
    assign crc_data   = crc_en_c ? load_data : '0;

endmodule

// File: tb/tb_fcs_tx_ctrl.sv
// Randomized self-checking bench for fcs_tx_ctrl with a behavioural CRC-32 engine
// and a frame-level reference model (pad to 60, append bit-reversed ~CRC).
module tb_fcs_tx_ctrl;

    typedef logic [7:0] byte_q_t[$];

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic        crc_init;
    logic        crc_enable;
    logic [7:0]  crc_data;
    logic [31:0] crc_value;

    int checks = 0;
    int failures = 0;

    fcs_tx_ctrl #(.DATA_WIDTH(8), .CRC_WIDTH(32), .MIN_PAYLOAD(60)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .crc_init   (crc_init),
        .crc_enable (crc_enable),
        .crc_data   (crc_data),
        .crc_value  (crc_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ b[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Engine model: an init in the same cycle as an enable seeds before absorbing.
    always @(posedge clock) begin
        if (crc_enable)
            crc_value <= crc_byte(crc_init ? 32'hFFFFFFFF : crc_value, crc_data);
        else if (crc_init)
            crc_value <= 32'hFFFFFFFF;
    end

    byte_q_t exp_q;
    logic    exp_last_q[$];
    byte_q_t rx_q;
    logic    rx_last_q[$];
    int      exp_en = 0;
    int      en_cnt = 0;
    bit      rand_ready = 1'b0;

    // Reference: padded frame, plain bitwise CRC, FCS bytes MSB-first, each bit-reversed.
    task automatic model_frame(input byte_q_t f);
        byte_q_t     body;
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        body = f;
        while (body.size() < 60) body.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (body[i]) c = crc_byte(c, body[i]);
        fcs = ~c;
        foreach (body[i]) begin
            exp_q.push_back(body[i]);
            exp_last_q.push_back(1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            b = fcs[31-8*k -: 8];
            exp_q.push_back(rev8(b));
            exp_last_q.push_back(k == 3);
        end
        exp_en += body.size();
    endtask

    bit         hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit         pend = 1'b0;
    logic [7:0] pend_data = 8'h00;

    always @(negedge clock) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
            pend      = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {24'd0, out_data}, {24'd0, hold_data});
            end
            if (pend) begin
                check("crc_byte_loaded", {23'd0, out_valid, out_data}, {23'd0, 1'b1, pend_data});
            end
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rx_last_q.push_back(out_last);
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            pend      = crc_enable;
            pend_data = crc_data;
            if (crc_enable) en_cnt++;
        end
    end

    always @(posedge clock) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic make_frame(input int n, output byte_q_t f);
        f.delete();
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
    endtask

    // Drives one frame; stops early (in_valid low) after abort_at accepted bytes if >= 0.
    task automatic send_frame(input byte_q_t f, input int gap_pct, input int abort_at);
        bit done;
        bit xfer;
        int cyc;
        for (int i = 0; i < f.size(); i++) begin
            if (abort_at >= 0 && i == abort_at) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clock);
                #1;
            end
            in_valid = 1'b1;
            in_data  = f[i];
            in_last  = (i == f.size() - 1);
            done = 1'b0;
            cyc  = 0;
            while (!done) begin
                @(negedge clock);
                xfer = in_ready;
                if (xfer && i == 0)
                    check("init_at_first_byte", {31'd0, crc_init}, 32'd1);
                @(posedge clock);
                #1;
                if (xfer) done = 1'b1;
                else if (++cyc > 3000) begin
                    check("in_ready_timeout", 32'(cyc), 32'd0);
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_and_compare(input string tag);
        int cyc;
        cyc = 0;
        while (rx_q.size() < exp_q.size() && cyc < 5000) begin
            @(posedge clock);
            cyc++;
        end
        repeat (10) @(posedge clock);
        #1;
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
            check($sformatf("%s_last%0d", tag, i), {31'd0, rx_last_q[i]}, {31'd0, exp_last_q[i]});
        end
        check({tag, "_crc_en_cnt"}, 32'(en_cnt), 32'(exp_en));
        $display("frame %s: out_bytes=%0d expected=%0d crc_enables=%0d", tag, rx_q.size(), exp_q.size(), en_cnt);
        rx_q.delete();
        rx_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        en_cnt = 0;
        exp_en = 0;
    endtask

    task automatic run_frame(input string tag, input int n, input int gap_pct, input bit rr);
        byte_q_t f;
        make_frame(n, f);
        rand_ready = rr;
        model_frame(f);
        send_frame(f, gap_pct, -1);
        finish_and_compare(tag);
        rand_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_crc_enable"}, {31'd0, crc_enable}, 32'd0);
        check({tag, "_crc_init"}, {31'd0, crc_init}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t f1;
        byte_q_t f2;
        byte_q_t one;

        repeat (3) @(posedge clock);
        #2;
        check_reset_values("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        run_frame("pkt96", 96, 0, 1'b0);

        one.delete();
        one.push_back(8'hAA);
        model_frame(one);
        send_frame(one, 0, -1);
        finish_and_compare("one_byte");

        run_frame("len60", 60, 0, 1'b0);
        run_frame("len59", 59, 0, 1'b0);
        run_frame("pkt96_rand", 96, 30, 1'b1);

        for (int t = 0; t < 3; t++)
            run_frame($sformatf("rnd%0d", t), $urandom_range(1, 150), 20, 1'b1);

        make_frame(70, f1);
        make_frame(10, f2);
        rand_ready = 1'b1;
        model_frame(f1);
        model_frame(f2);
        send_frame(f1, 0, -1);
        send_frame(f2, 0, -1);
        finish_and_compare("b2b");
        rand_ready = 1'b0;

        make_frame(96, f1);
        send_frame(f1, 0, 30);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        rx_q.delete();
        rx_last_q.delete();
        en_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        run_frame("after_reset", 64, 10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
